bit_serializer: RTL and testbench

//  Parallel-to-serial front end for the "111" sequence detector. Accepts WIDTH-bit

---
 rtl/serializer_pkg.sv | 10 +
 rtl/bit_serializer_if.sv | 22 ++
 rtl/bit_counter.sv | 34 +++
 rtl/bit_serializer.sv | 100 ++++++++++
 tb/tb_bit_serializer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer and its counter.
package serializer_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  function automatic int cnt_w(int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle between the upstream word source and the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, word_done, busy
  );
endinterface

// File: rtl/bit_counter.sv
// Bit-position counter: 0..WIDTH-1, saturates on the last bit, flags it.
module bit_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    inc_i,
  output logic [cnt_w(WIDTH)-1:0] cnt_o,
  output logic                    last_o
);
  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i && !last_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word intake, one bit per clock out,
// back-to-back words stream with no gap, line parked at IDLE_BIT otherwise.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  bit_serializer_if.slave ser
);
  localparam int            CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             word_done_q, word_done_d;
  logic [CW-1:0]    cnt;
  logic             last, xfer, cnt_clear, cnt_inc;

  function automatic logic first_bit(logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .cnt_o   (cnt),
    .last_o  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = SHIFT;
      SHIFT:   if (last && !xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready on the last bit lets the next word follow with zero gap.
  always_comb begin
    ser.din_ready = (state_q == IDLE) || ((state_q == SHIFT) && last);
    ser.busy      = (state_q == SHIFT);
    xfer          = ser.din_valid && ser.din_ready;
    cnt_clear     = xfer;
    cnt_inc       = (state_q == SHIFT) && !last;
  end

  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  // The output bit is registered together with the shift, so sout always
  // shows the bit at the head of the word the counter is pointing at.
  always_comb begin
    shreg_d      = shreg_q;
    sout_d       = IDLE_BIT;
    sout_valid_d = 1'b0;
    word_done_d  = 1'b0;
    if (xfer) begin
      shreg_d      = ser.din;
      sout_d       = first_bit(ser.din);
      sout_valid_d = 1'b1;
    end else if ((state_q == SHIFT) && !last) begin
      shreg_d      = shifted;
      sout_d       = first_bit(shifted);
      sout_valid_d = 1'b1;
      word_done_d  = (cnt == PENULT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q      <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      word_done_q  <= word_done_d;
    end
  end

  assign ser.sout       = sout_q;
  assign ser.sout_valid = sout_valid_q;
  assign ser.word_done  = word_done_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed scenarios plus random streaming checked
// against a bit-stream reference model (queue of pending output bits).
module tb_bit_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) a_if ();
  bit_serializer_if #(.WIDTH(8)) b_if ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .ser(a_if.slave)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .ser(b_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference: queue of bits still to appear on the line, head = current bit.
  bit qa_bit[$], qa_done[$], qb_bit[$], qb_done[$];
  bit take_a, take_b;

  always @(posedge clk) begin
    take_a = a_if.din_valid && (qa_bit.size() <= 1);
    if (reset) begin
      qa_bit.delete(); qa_done.delete();
    end else begin
      if (qa_bit.size() > 0) begin
        void'(qa_bit.pop_front()); void'(qa_done.pop_front());
      end
      if (take_a)
        for (int i = 0; i < 8; i++) begin
          qa_bit.push_back(a_if.din[7-i]);
          qa_done.push_back(i == 7);
        end
    end
  end

  always @(posedge clk) begin
    take_b = b_if.din_valid && (qb_bit.size() <= 1);
    if (reset) begin
      qb_bit.delete(); qb_done.delete();
    end else begin
      if (qb_bit.size() > 0) begin
        void'(qb_bit.pop_front()); void'(qb_done.pop_front());
      end
      if (take_b)
        for (int i = 0; i < 8; i++) begin
          qb_bit.push_back(b_if.din[i]);
          qb_done.push_back(i == 7);
        end
    end
  end

  // Observed vector: {sout, sout_valid, word_done, busy, din_ready}
  function automatic logic [4:0] obs_a();
    return {a_if.sout, a_if.sout_valid, a_if.word_done, a_if.busy, a_if.din_ready};
  endfunction

  function automatic logic [4:0] obs_b();
    return {b_if.sout, b_if.sout_valid, b_if.word_done, b_if.busy, b_if.din_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_if.din_valid = 1'b1; a_if.din = 8'($urandom);
    b_if.din_valid = 1'b1; b_if.din = 8'($urandom);
    tick(); tick();
    reset = 1'b0;
    a_if.din_valid = 1'b0; b_if.din_valid = 1'b0;
    total++;
    if (obs_a() !== 5'b00001) begin
      bad++; $display("FAIL reset_a got=%b exp=%b", obs_a(), 5'b00001);
    end
    total++;
    if (obs_b() !== 5'b00001) begin
      bad++; $display("FAIL reset_b got=%b exp=%b", obs_b(), 5'b00001);
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [4:0] exp;
    w = 8'hE0;
    a_if.din = w; a_if.din_valid = 1'b1;
    tick();
    a_if.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {w[7-i], 1'b1, 1'(i == 7), 1'b1, 1'(i == 7)};
      total++;
      if (obs_a() !== exp) begin
        bad++; $display("FAIL single bit%0d got=%b exp=%b", i, obs_a(), exp);
      end
      tick();
    end
    total++;
    if (obs_a() !== 5'b00001) begin
      bad++; $display("FAIL single_idle got=%b exp=%b", obs_a(), 5'b00001);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    logic       lst;
    a_if.din = 8'hFF; a_if.din_valid = 1'b1;
    tick();
    a_if.din = 8'h00;
    for (int i = 0; i < 16; i++) begin
      lst = (i == 7) || (i == 15);
      exp = {1'(i < 8), 1'b1, lst, 1'b1, lst};
      total++;
      if (obs_a() !== exp) begin
        bad++; $display("FAIL b2b bit%0d got=%b exp=%b", i, obs_a(), exp);
      end
      if (i == 15) a_if.din_valid = 1'b0;
      tick();
    end
    total++;
    if (obs_a() !== 5'b00001) begin
      bad++; $display("FAIL b2b_idle got=%b exp=%b", obs_a(), 5'b00001);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] ws[2];
    logic [7:0] w;
    logic [4:0] exp;
    ws = '{8'h07, 8'hE0};
    for (int k = 0; k < 2; k++) begin
      w = ws[k];
      b_if.din = w; b_if.din_valid = 1'b1;
      tick();
      b_if.din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        exp = {w[i], 1'b1, 1'(i == 7), 1'b1, 1'(i == 7)};
        total++;
        if (obs_b() !== exp) begin
          bad++; $display("FAIL lsb w=%h bit%0d got=%b exp=%b", w, i, obs_b(), exp);
        end
        tick();
      end
      total++;
      if (obs_b() !== 5'b00001) begin
        bad++; $display("FAIL lsb_idle got=%b exp=%b", obs_b(), 5'b00001);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    logic [4:0] exp;
    w = 8'hAA;
    a_if.din = w; a_if.din_valid = 1'b1;
    tick();
    a_if.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {w[7-i], 1'b1, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs_a() !== exp) begin
        bad++; $display("FAIL rstmid bit%0d got=%b exp=%b", i, obs_a(), exp);
      end
      if (i < 2) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (obs_a() !== 5'b00001) begin
      bad++; $display("FAIL rstmid_abort got=%b exp=%b", obs_a(), 5'b00001);
    end
    w = 8'h01;
    a_if.din = w; a_if.din_valid = 1'b1;
    tick();
    a_if.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {w[7-i], 1'b1, 1'(i == 7), 1'b1, 1'(i == 7)};
      total++;
      if (obs_a() !== exp) begin
        bad++; $display("FAIL rstmid_new bit%0d got=%b exp=%b", i, obs_a(), exp);
      end
      tick();
    end
  endtask

  task automatic test_din_change();
    logic [7:0] w1, w2;
    logic [4:0] exp;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    a_if.din = w1; a_if.din_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp = {w1[7-i], 1'b1, 1'(i == 7), 1'b1, 1'(i == 7)};
      total++;
      if (obs_a() !== exp) begin
        bad++; $display("FAIL dinchg w1 bit%0d got=%b exp=%b", i, obs_a(), exp);
      end
      a_if.din = (i < 7) ? 8'($urandom) : w2;
      tick();
    end
    a_if.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {w2[7-i], 1'b1, 1'(i == 7), 1'b1, 1'(i == 7)};
      total++;
      if (obs_a() !== exp) begin
        bad++; $display("FAIL dinchg w2 bit%0d got=%b exp=%b", i, obs_a(), exp);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [4:0] expa, expb;
    for (int c = 0; c < 800; c++) begin
      expa = (qa_bit.size() > 0)
           ? {qa_bit[0], 1'b1, qa_done[0], 1'b1, 1'(qa_bit.size() == 1)} : 5'b00001;
      expb = (qb_bit.size() > 0)
           ? {qb_bit[0], 1'b1, qb_done[0], 1'b1, 1'(qb_bit.size() == 1)} : 5'b00001;
      total++;
      if (obs_a() !== expa) begin
        bad++; $display("FAIL rand_a cyc%0d got=%b exp=%b", c, obs_a(), expa);
      end
      total++;
      if (obs_b() !== expb) begin
        bad++; $display("FAIL rand_b cyc%0d got=%b exp=%b", c, obs_b(), expb);
      end
      reset          = ($urandom_range(63) == 0);
      a_if.din_valid = ($urandom_range(99) < 60);
      b_if.din_valid = ($urandom_range(99) < 60);
      a_if.din       = 8'($urandom);
      b_if.din       = 8'($urandom);
      tick();
    end
    reset = 1'b0;
    a_if.din_valid = 1'b0;
    b_if.din_valid = 1'b0;
  endtask

  initial begin
    a_if.din = '0; a_if.din_valid = 1'b0;
    b_if.din = '0; b_if.din_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid();
    test_din_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
